multi_delay_timer: RTL and testbench

Multi-channel, runtime-programmable successor to the single-shot delay timer. Each of `CHANNELS` independent timers starts on a rising edge of its `enable` bit. After a programmable number of clock cycles it emits a one-cycle `done` pulse. Each channel runs either one-shot or periodic (auto-reload), and can be cancelled. It sits between control FSMs and the peripherals that need settle, timeout or tick intervals.

---
 rtl/multi_delay_timer.sv | 130 +++++++++++++
 tb/tb_multi_delay_timer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_delay_timer
// Purpose  : CHANNELS independent, runtime-programmable delay timers. Each
//            channel starts (or restarts) on a rising edge of its enable bit
//            and emits a one-cycle done pulse after dly[ch] clock cycles,
//            either once (one-shot) or repeatedly (periodic auto-reload).
// Ports    : clk          - clock, all state on posedge
//            rst_n        - asynchronous active-low reset
//            enable[ch]   - rising edge starts/restarts channel ch
//            cancel[ch]   - level-sensitive abort of channel ch
//            periodic[ch] - 1 = auto-reload at expiry, 0 = one-shot
//            load_valid   - write load_value into dly[load_chan]
//            load_chan    - load target; values >= CHANNELS are ignored
//            load_value   - new delay in clock cycles
//            done[ch]     - one-cycle expiry pulse
//            busy[ch]     - channel counter non-zero
//            any_done     - OR of done, registered alongside done
// Revision : 1.0 - initial release
// ============================================================================
module multi_delay_timer #(
    parameter int CHANNELS     = 4,
    parameter int DELAY_PERIOD = 1000,
    parameter int CYCLE_TIME   = 10,
    parameter int ROUND_MODE   = 0,
    parameter int CNT_WIDTH    = 16,
    parameter int CHAN_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  enable,
    input  logic [CHANNELS-1:0]  cancel,
    input  logic [CHANNELS-1:0]  periodic,
    input  logic                 load_valid,
    input  logic [CHAN_W-1:0]    load_chan,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic [CHANNELS-1:0]  done,
    output logic [CHANNELS-1:0]  busy,
    output logic                 any_done
);

    localparam int c_DELAY_CYCLE = (ROUND_MODE != 0)
                                 ? (DELAY_PERIOD + CYCLE_TIME - 1) / CYCLE_TIME
                                 : DELAY_PERIOD / CYCLE_TIME;

    localparam logic [CNT_WIDTH-1:0] c_DLY_RST = CNT_WIDTH'(c_DELAY_CYCLE);
    localparam logic [CNT_WIDTH-1:0] c_ONE     = CNT_WIDTH'(1);

    // Shift form avoids overflowing 2**CNT_WIDTH for wide counters.
    generate
        if ((c_DELAY_CYCLE >> CNT_WIDTH) != 0) begin : g_bad_width
            $error("multi_delay_timer: DELAY_CYCLE does not fit in CNT_WIDTH");
        end
    endgenerate

    logic [CHANNELS-1:0] w_done_nxt;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            logic [CNT_WIDTH-1:0] r_dly;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic                 r_prev_en;
            logic                 r_done;
            logic [CNT_WIDTH-1:0] w_cnt_nxt;
            logic                 w_edge;
            logic                 w_load_hit;

            assign w_edge = enable[g] & ~r_prev_en;
            // An out-of-range load_chan matches no channel index, so it is
            // dropped without any extra range check.
            assign w_load_hit = load_valid && (load_chan == CHAN_W'(g));

            // Priority: cancel > start edge > count down > expiry.
            // The start reads the registered r_dly, so a load in the same
            // cycle as an edge only affects later starts and reloads.
            always_comb begin
                w_cnt_nxt     = r_cnt;
                w_done_nxt[g] = 1'b0;
                if (cancel[g]) begin
                    w_cnt_nxt = '0;
                end else if (w_edge) begin
                    // A zero delay fires immediately and leaves the counter
                    // idle, so periodic mode cannot free-run at dly = 0.
                    w_cnt_nxt     = r_dly;
                    w_done_nxt[g] = (r_dly == '0);
                end else if (r_cnt > c_ONE) begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end else if (r_cnt == c_ONE) begin
                    w_done_nxt[g] = 1'b1;
                    w_cnt_nxt     = periodic[g] ? r_dly : '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly     <= c_DLY_RST;
                    r_cnt     <= '0;
                    r_prev_en <= 1'b0;
                    r_done    <= 1'b0;
                end else begin
                    r_prev_en <= enable[g];
                    r_cnt     <= w_cnt_nxt;
                    r_done    <= w_done_nxt[g];
                    if (w_load_hit) begin
                        r_dly <= load_value;
                    end
                end
            end

            assign done[g] = r_done;
            assign busy[g] = (r_cnt != '0);
        end
    endgenerate

    // Registered from the same next-state terms as done, so it lines up
    // with the done pulses instead of lagging them by a cycle.
    logic r_any_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_done <= 1'b0;
        end else begin
            r_any_done <= |w_done_nxt;
        end
    end

    assign any_done = r_any_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_delay_timer
// Purpose  : Directed self-checking bench for multi_delay_timer. Instance A
//            uses CHANNELS=4, 55/10 floor (D=5); instance B uses CHANNELS=3,
//            55/10 ceiling (D=6), which also leaves load_chan=3 encodable as
//            an out-of-range channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_delay_timer;

    logic        clk;
    logic        rst_n;

    logic [3:0]  a_en, a_cancel, a_per, a_done, a_busy;
    logic        a_lv, a_any;
    logic [1:0]  a_lc;
    logic [15:0] a_lval;

    logic [2:0]  b_en, b_cancel, b_per, b_done, b_busy;
    logic        b_lv, b_any;
    logic [1:0]  b_lc;
    logic [15:0] b_lval;

    int n_checks;
    int n_fail;

    multi_delay_timer #(
        .CHANNELS(4), .DELAY_PERIOD(55), .CYCLE_TIME(10), .ROUND_MODE(0), .CNT_WIDTH(16)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .enable(a_en), .cancel(a_cancel), .periodic(a_per),
        .load_valid(a_lv), .load_chan(a_lc), .load_value(a_lval),
        .done(a_done), .busy(a_busy), .any_done(a_any)
    );

    multi_delay_timer #(
        .CHANNELS(3), .DELAY_PERIOD(55), .CYCLE_TIME(10), .ROUND_MODE(1), .CNT_WIDTH(16)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .enable(b_en), .cancel(b_cancel), .periodic(b_per),
        .load_valid(b_lv), .load_chan(b_lc), .load_value(b_lval),
        .done(b_done), .busy(b_busy), .any_done(b_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n posedges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_en = '0; a_cancel = '0; a_per = '0; a_lv = 1'b0; a_lc = '0; a_lval = '0;
        b_en = '0; b_cancel = '0; b_per = '0; b_lv = 1'b0; b_lc = '0; b_lval = '0;
        step(2);
        n_checks++;
        if ({a_done, a_busy, a_any} !== 9'b0) begin
            n_fail++; $display("FAIL reset_a got=%b exp=0", {a_done, a_busy, a_any});
        end
        n_checks++;
        if ({b_done, b_busy, b_any} !== 7'b0) begin
            n_fail++; $display("FAIL reset_b got=%b exp=0", {b_done, b_busy, b_any});
        end
        #3 rst_n = 1'b1;
        step(1);
    endtask

    // D=5 one-shot on A channel 0: done only after posedge k+5.
    task automatic test_oneshot();
        a_en[0] = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            step(1);
            if (c == 0) a_en[0] = 1'b0;
            n_checks++;
            if (a_done[0] !== (c == 5) || a_busy[0] !== (c < 5) || a_any !== (c == 5)) begin
                n_fail++;
                $display("FAIL oneshot c=%0d done=%b busy=%b any=%b exp done=%b busy=%b",
                         c, a_done[0], a_busy[0], a_any, (c == 5), (c < 5));
            end
        end
    endtask

    // D=6 periodic on B channel 1; periodic cleared from posedge 14 on.
    task automatic test_periodic();
        b_per[1] = 1'b1;
        b_en[1]  = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            step(1);
            if (c == 0)  b_en[1]  = 1'b0;
            if (c == 13) b_per[1] = 1'b0;
            n_checks++;
            if (b_done[1] !== (c == 6 || c == 12 || c == 18) || b_busy[1] !== (c < 18)) begin
                n_fail++;
                $display("FAIL periodic c=%0d done=%b busy=%b exp done=%b busy=%b",
                         c, b_done[1], b_busy[1], (c == 6 || c == 12 || c == 18), (c < 18));
            end
        end
    endtask

    // load_chan=3 on the 3-channel instance must not touch any dly.
    task automatic test_load_out_of_range();
        b_lv = 1'b1; b_lc = 2'd3; b_lval = 16'd2;
        step(1);
        b_lv = 1'b0;
        b_en = 3'b101;
        for (int c = 0; c <= 7; c++) begin
            step(1);
            if (c == 0) b_en = 3'b000;
            n_checks++;
            if (b_done !== ((c == 6) ? 3'b101 : 3'b000) ||
                b_busy !== ((c < 6) ? 3'b101 : 3'b000)) begin
                n_fail++;
                $display("FAIL load_oob c=%0d done=%b busy=%b exp done=%b busy=%b", c, b_done,
                         b_busy, (c == 6) ? 3'b101 : 3'b000, (c < 6) ? 3'b101 : 3'b000);
            end
        end
    endtask

    // A channel 2: load during a count, then load coincident with an edge.
    task automatic test_load();
        a_lv = 1'b1; a_lc = 2'd2; a_lval = 16'd10;
        step(1);
        a_lv = 1'b0;
        a_en[2] = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            step(1);
            if (c == 0) a_en[2] = 1'b0;
            if (c == 3) begin a_lv = 1'b1; a_lval = 16'd3; end
            if (c == 4) a_lv = 1'b0;
            n_checks++;
            if (a_done[2] !== (c == 10) || a_busy[2] !== (c < 10)) begin
                n_fail++;
                $display("FAIL load_run c=%0d done=%b busy=%b exp done=%b busy=%b",
                         c, a_done[2], a_busy[2], (c == 10), (c < 10));
            end
        end
        // Edge with dly=3 while loading 7: this start still uses 3.
        a_en[2] = 1'b1; a_lv = 1'b1; a_lval = 16'd7;
        for (int c = 0; c <= 4; c++) begin
            step(1);
            if (c == 0) begin a_en[2] = 1'b0; a_lv = 1'b0; end
            n_checks++;
            if (a_done[2] !== (c == 3) || a_busy[2] !== (c < 3)) begin
                n_fail++;
                $display("FAIL load_edge c=%0d done=%b busy=%b exp done=%b busy=%b",
                         c, a_done[2], a_busy[2], (c == 3), (c < 3));
            end
        end
        a_en[2] = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            step(1);
            if (c == 0) a_en[2] = 1'b0;
            n_checks++;
            if (a_done[2] !== (c == 7) || a_busy[2] !== (c < 7)) begin
                n_fail++;
                $display("FAIL load_next c=%0d done=%b busy=%b exp done=%b busy=%b",
                         c, a_done[2], a_busy[2], (c == 7), (c < 7));
            end
        end
    endtask

    // A channel 3, D=8: second edge at k+4 gives a single done at k+12.
    task automatic test_retrigger();
        a_lv = 1'b1; a_lc = 2'd3; a_lval = 16'd8;
        step(1);
        a_lv = 1'b0;
        a_en[3] = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            step(1);
            if (c == 0) a_en[3] = 1'b0;
            if (c == 3) a_en[3] = 1'b1;
            if (c == 4) a_en[3] = 1'b0;
            n_checks++;
            if (a_done[3] !== (c == 12) || a_busy[3] !== (c < 12)) begin
                n_fail++;
                $display("FAIL retrigger c=%0d done=%b busy=%b exp done=%b busy=%b",
                         c, a_done[3], a_busy[3], (c == 12), (c < 12));
            end
        end
    endtask

    task automatic test_cancel();
        // Cancel together with an edge: nothing starts.
        a_cancel[3] = 1'b1; a_en[3] = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            step(1);
            if (c == 0) begin a_cancel[3] = 1'b0; a_en[3] = 1'b0; end
            n_checks++;
            if (a_done[3] !== 1'b0 || a_busy[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL cancel_edge c=%0d done=%b busy=%b exp 0 0", c, a_done[3], a_busy[3]);
            end
        end
        // Cancel mid-count: busy drops after the cancel edge, no done.
        a_en[3] = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            step(1);
            if (c == 0) a_en[3] = 1'b0;
            if (c == 2) a_cancel[3] = 1'b1;
            if (c == 3) a_cancel[3] = 1'b0;
            n_checks++;
            if (a_done[3] !== 1'b0 || a_busy[3] !== (c < 3)) begin
                n_fail++;
                $display("FAIL cancel_mid c=%0d done=%b busy=%b exp done=0 busy=%b",
                         c, a_done[3], a_busy[3], (c < 3));
            end
        end
    endtask

    // dly=0 on A channel 0, one-shot then periodic: one pulse each, no busy.
    task automatic test_zero_delay();
        a_lv = 1'b1; a_lc = 2'd0; a_lval = 16'd0;
        step(1);
        a_lv = 1'b0;
        for (int m = 0; m < 2; m++) begin
            a_per[0] = (m == 1);
            a_en[0]  = 1'b1;
            for (int c = 0; c <= 5; c++) begin
                step(1);
                if (c == 0) a_en[0] = 1'b0;
                n_checks++;
                if (a_done[0] !== (c == 0) || a_busy[0] !== 1'b0 || a_any !== (c == 0)) begin
                    n_fail++;
                    $display("FAIL zero_delay m=%0d c=%0d done=%b busy=%b any=%b exp done=%b busy=0",
                             m, c, a_done[0], a_busy[0], a_any, (c == 0));
                end
            end
        end
        a_per[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_en = 4'b1110;
        step(1);
        a_en = 4'b0000;
        step(2);
        n_checks++;
        if (a_busy !== 4'b1110) begin
            n_fail++; $display("FAIL pre_reset busy=%b exp=1110", a_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_done !== 4'b0 || a_busy !== 4'b0 || a_any !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset done=%b busy=%b any=%b exp 0", a_done, a_busy, a_any);
        end
        a_en = 4'b1111;
        #2 rst_n = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            step(1);
            n_checks++;
            if (a_busy !== ((c < 5) ? 4'b1111 : 4'b0000) ||
                a_done !== ((c == 5) ? 4'b1111 : 4'b0000) || a_any !== (c == 5)) begin
                n_fail++;
                $display("FAIL reset_release c=%0d done=%b busy=%b any=%b exp done=%b busy=%b",
                         c, a_done, a_busy, a_any, (c == 5) ? 4'b1111 : 4'b0000,
                         (c < 5) ? 4'b1111 : 4'b0000);
            end
        end
        a_en = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_load_out_of_range();
        test_load();
        test_retrigger();
        test_cancel();
        test_zero_delay();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
